// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate / logical / arithmetic shifter, one register stage per binary shift level.
// Optional out_zero result flag is built when BSH_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    input  logic                     in_dir,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef BSH_ZERO_FLAG_EN
    ,
    output logic                     out_zero
`endif
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam logic [1:0] MODE_ROT   = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b10;

    // Shift by a fixed power of two; reserved mode 11 falls into the logical branch.
    function automatic logic [WIDTH-1:0] shift_pow2(input logic [WIDTH-1:0] d, input int s,
                                                    input logic [1:0] mode, input logic dir);
        logic [2*WIDTH-1:0] dd;
        logic [WIDTH-1:0]   r;
        dd = {d, d};
        if (mode == MODE_ROT) begin
            if (dir) begin
                dd = dd >> s;
                r  = dd[WIDTH-1:0];
            end else begin
                dd = dd << s;
                r  = dd[2*WIDTH-1:WIDTH];
            end
        end else if (dir) begin
            if (mode == MODE_ARITH) r = $signed(d) >>> s;
            else                    r = d >> s;
        end else begin
            r = d << s;
        end
        return r;
    endfunction

    logic [LOG2W-1:0] vld;
    logic [LOG2W-1:0] load;

    // A stage may load when empty or when its current content leaves this cycle.
    always_comb begin
        load = '0;
        load[LOG2W-1] = !vld[LOG2W-1] || out_ready;
        for (int k = LOG2W - 2; k >= 0; k--)
            load[k] = !vld[k] || load[k+1];
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        logic               v_in;
        logic [WIDTH-1:0]   d_in;
        logic [LOG2W-1-k:0] a_in;
        logic [1:0]         m_in;
        logic               r_in;
        logic [WIDTH-1:0]   d_shift;
        logic               v_r;
        logic [WIDTH-1:0]   d_r;

        if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign d_in = in_data;
            assign a_in = in_amt;
            assign m_in = in_mode;
            assign r_in = in_dir;
        end else begin : g_src
            assign v_in = g_stage[k-1].v_r;
            assign d_in = g_stage[k-1].d_r;
            assign a_in = g_stage[k-1].g_fwd.a_r;
            assign m_in = g_stage[k-1].g_fwd.m_r;
            assign r_in = g_stage[k-1].g_fwd.r_r;
        end

        // a_in[0] is always this stage's amount bit; consumed bits are dropped downstream.
        assign d_shift = a_in[0] ? shift_pow2(d_in, 1 << k, m_in, r_in) : d_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                d_r <= '0;
            end else if (load[k]) begin
                v_r <= v_in;
                if (v_in) d_r <= d_shift;
            end
        end

        assign vld[k] = v_r;

        if (k < LOG2W - 1) begin : g_fwd
            logic [LOG2W-2-k:0] a_r;
            logic [1:0]         m_r;
            logic               r_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    m_r <= '0;
                    r_r <= 1'b0;
                end else if (load[k] && v_in) begin
                    a_r <= a_in[LOG2W-1-k:1];
                    m_r <= m_in;
                    r_r <= r_in;
                end
            end
        end
    end

    assign out_valid = vld[LOG2W-1];
    assign out_data  = g_stage[LOG2W-1].d_r;

`ifdef BSH_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_zero <= 1'b0;
        else if (load[LOG2W-1] && g_stage[LOG2W-1].v_in)
            out_zero <= ~|g_stage[LOG2W-1].d_shift;
    end
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed + random bench for pipelined_barrel_shifter (WIDTH=16) with an in-order scoreboard.
// Checks out_zero as well when BSH_ZERO_FLAG_EN is defined.
module tb_pipelined_barrel_shifter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [3:0]   in_amt = '0;
    logic [1:0]   in_mode = '0;
    logic         in_dir = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef BSH_ZERO_FLAG_EN
    logic         out_zero;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BSH_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    // Bit-by-bit reference: each result bit looks up its source bit directly.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [3:0] a,
                                               input logic [1:0] m, input logic dir);
        logic [W-1:0] r;
        int src;
        logic [31:0] s32;
        for (int i = 0; i < W; i++) begin
            src = dir ? i + int'(a) : i - int'(a);
            s32 = src;
            if (src >= 0 && src < W) r[i] = d[s32[3:0]];
            else if (m == 2'b00)     r[i] = d[s32[3:0]];
            else if (m == 2'b10 && dir) r[i] = d[W-1];
            else                     r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the operand.
    task automatic drive(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m, input logic dr);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_dir = dr;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        chk("accept", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m,
                             input logic dr, input logic [W-1:0] exp);
        int n;
        drive(d, a, m, dr);
        n = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        chk("latency", n, 4);
        chk("directed", {16'd0, out_data}, {16'd0, exp});
`ifdef BSH_ZERO_FLAG_EN
        chk("directed_zero", {31'd0, out_zero}, {31'd0, exp == '0});
`endif
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Scoreboard: push on accept, pop/compare on output transfer.
    initial begin : mon
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    total++;
                    assert (sb.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_output observed=%h expected=no result", out_data);
                    end
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        chk("result", {16'd0, out_data}, {16'd0, exp});
`ifdef BSH_ZERO_FLAG_EN
                        chk("zero_flag", {31'd0, out_zero}, {31'd0, exp == '0});
`endif
                    end
                end
                if (in_valid && in_ready)
                    sb.push_back(ref_shift(in_data, in_amt, in_mode, in_dir));
            end
        end
    end

    initial begin : stim
        int  c0;
        bit  seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_out_valid", {31'd0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {16'd0, out_data}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Directed operations with known results
        lat_check(16'h8001, 4'd1,  2'b00, 1'b0, 16'h0003);
        lat_check(16'h8001, 4'd1,  2'b00, 1'b1, 16'hC000);
        lat_check(16'h8000, 4'd15, 2'b01, 1'b1, 16'h0001);
        lat_check(16'h8000, 4'd4,  2'b10, 1'b1, 16'hF800);
        lat_check(16'h0F0F, 4'd4,  2'b10, 1'b0, 16'hF0F0);
        lat_check(16'h8000, 4'd15, 2'b11, 1'b1, 16'h0001);
        lat_check(16'h00F0, 4'd4,  2'b11, 1'b0, 16'h0F00);
        lat_check(16'hA5C3, 4'd0,  2'b10, 1'b1, 16'hA5C3);
        lat_check(16'hA5C3, 4'd0,  2'b00, 1'b0, 16'hA5C3);
        lat_check(16'h8000, 4'd4,  2'b10, 1'b0, 16'h0000);
        lat_check(16'h7000, 4'd4,  2'b10, 1'b1, 16'h0700);
        lat_check(16'h0001, 4'd1,  2'b01, 1'b1, 16'h0000);
        lat_check(16'h0001, 4'd1,  2'b00, 1'b1, 16'h8000);
        drain();

        // Back-to-back random stream
        c0 = cyc;
        for (int i = 0; i < 100; i++)
            drive(W'($urandom), 4'($urandom_range(15)), 2'($urandom_range(3)), 1'($urandom_range(1)));
        chk("stream_cycles", cyc - c0, 100);
        drain();

        // Backpressure: fill the pipe, then hold out_ready low
        out_ready = 1'b0;
        drive(16'h1234, 4'd3, 2'b00, 1'b0);
        drive(16'hF00D, 4'd5, 2'b10, 1'b1);
        drive(16'h0FF0, 4'd8, 2'b01, 1'b0);
        drive(16'h8421, 4'd2, 2'b11, 1'b1);
        in_valid = 1'b1; in_data = 16'hBEEF; in_amt = 4'd7; in_mode = 2'b00; in_dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            chk("bp_out_valid", {31'd0, out_valid}, 1);
            chk("bp_hold", {16'd0, out_data}, 32'h91A0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drive(16'hBEEF, 4'd7, 2'b00, 1'b1);
        drain();

        // Reset with three operands in flight
        drive(16'h1111, 4'd1, 2'b00, 1'b0);
        drive(16'h2222, 4'd2, 2'b01, 1'b1);
        drive(16'h3333, 4'd3, 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 0);
        chk("rst_mid_out_data", {16'd0, out_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_stale", {31'd0, seen}, 0);
        lat_check(16'h00F0, 4'd2, 2'b01, 1'b1, 16'h003C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
